calib_pulse_seq: RTL and testbench
==================================

Name: calib_pulse_seq

Overview:
Sequencer that drives the DCFEB calibration pulse outputs (injection and external pulse) from trigger requests.
- Produces programmable delay, width, pulse-train count and inter-pulse gap.
- Arbitrates between injection and external requests, with one-deep pending storage per type.
- Sits between the synchronized trigger/command sources and the differential output buffers of the calibration interface; its INJ_PLS/EXT_PLS outputs feed those buffers directly.

Parameters:
DLY_W, 8, width of delay setting (cycles)
WID_W, 4, width of pulse-width and gap settings (cycles)
CNT_W, 8, width of pulse-train count and drop counter

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
ENABLE  in  1  sequencer enable; low aborts and ignores requests
INJ_REQ  in  1  injection request, synchronized, level sampled each cycle
EXT_REQ  in  1  external-pulse request, synchronized, level sampled each cycle
DLY  in  DLY_W  cycles from request acceptance to first pulse edge
WIDTH  in  WID_W  pulse high time in cycles (0 treated as 1)
GAP  in  WID_W  low time between train pulses in cycles (0 treated as 1)
NPULSE  in  CNT_W  pulses per train (0 treated as 1)
INJ_PLS  out  1  registered injection pulse to output buffer
EXT_PLS  out  1  registered external pulse to output buffer
BUSY  out  1  high while a train is in progress
DONE  out  1  one-cycle strobe at end of each train
DROP_CNT  out  CNT_W  requests lost to full pending slot; saturating

Behaviour:
- All outputs are registered. Reset values: INJ_PLS=0, EXT_PLS=0, BUSY=0, DONE=0, DROP_CNT=0. State=IDLE, pending flags cleared.
- Request capture:
  - A request is a rising edge of INJ_REQ/EXT_REQ (the block keeps its own delayed copy of each).
  - Edge while ENABLE=0: ignored, not counted.
- Pending slots: one per type.
  - An edge that cannot start immediately sets its slot.
  - An edge whose slot is already set increments DROP_CNT (saturates at all-ones).
- Arbitration in IDLE:
  - Fresh or pending INJ has priority over EXT.
  - INJ and EXT edges in the same cycle: INJ starts; EXT goes to its pending slot.
- States: IDLE, DELAY, HIGH, GAP.
  - IDLE -> DELAY on acceptance at edge k. DLY, WIDTH, GAP and NPULSE are latched at acceptance; later changes do not affect the running train.
  - DELAY lasts DLY cycles. The selected output goes high on edge k+1+DLY, so DLY=0 gives a high output one cycle after acceptance.
  - HIGH lasts max(WIDTH,1) cycles.
  - HIGH -> GAP if pulses remain; GAP lasts max(GAP,1) cycles with the output low, then -> HIGH.
  - After the last pulse: output falls, DONE=1 for that one cycle, state -> IDLE.
- BUSY: high from edge k+1 through the cycle the last pulse is high; low in the DONE cycle.
- Back-to-back trains: IDLE may accept a pending request in the cycle after DONE, giving a minimum 1-cycle low between trains.
- Only one of INJ_PLS/EXT_PLS is ever high; never both.
- ENABLE falling mid-train:
  - At the next edge: both outputs 0, state -> IDLE, pending slots cleared.
  - DONE is not asserted; DROP_CNT is held.
- RST mid-train: at the next edge all outputs and state return to reset values.
- Counters: delay/width/gap counters load N-1 and count down to 0. The pulse counter decrements at each HIGH exit. No wrap: all settings are bounded by the latched values.

Test Plan:
1. Reset, ENABLE=1, DLY=3, WIDTH=2, NPULSE=1, INJ_REQ edge at cycle 10 -> INJ_PLS high cycles 14-15, DONE at 16, BUSY high 11-15, EXT_PLS stays 0.
2. DLY=0, WIDTH=0, GAP=0, NPULSE=3, EXT_REQ edge at cycle 5 -> EXT_PLS high at 6, 8, 10 (1 cycle each), DONE at 11.
3. INJ and EXT edges same cycle (DLY=1, WIDTH=1, NPULSE=1) at cycle 20 -> INJ_PLS high at 22, DONE 23, EXT accepted 24, EXT_PLS high at 26, DONE 27; DROP_CNT=0.
4. During a long train (DLY=10), 3 further INJ_REQ edges -> first sets pending, DROP_CNT=2, and exactly one extra INJ train follows.
5. ENABLE dropped while HIGH, with an EXT request pending -> outputs 0 next edge, no DONE, no EXT train afterwards; re-enable and a new request produces a normal train.
6. RST asserted mid-GAP with DROP_CNT=5 -> next edge all outputs 0, DROP_CNT=0, state IDLE; 300 dropped requests -> DROP_CNT saturates at 255.

Source files
------------

// File: rtl/calib_pulse_seq_if.sv
// Request/setting inputs and pulse/status outputs of the calibration pulse sequencer.
// Latency: none; this is a plain wiring bundle.
// Backpressure: none; requests are edge-sampled levels and outputs are free-running.
interface calib_pulse_seq_if #(
  parameter int DLY_W = 8,
  parameter int WID_W = 4,
  parameter int CNT_W = 8
);
  logic             ENABLE;
  logic             INJ_REQ;
  logic             EXT_REQ;
  logic [DLY_W-1:0] DLY;
  logic [WID_W-1:0] WIDTH;
  logic [WID_W-1:0] GAP;
  logic [CNT_W-1:0] NPULSE;
  logic             INJ_PLS;
  logic             EXT_PLS;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] DROP_CNT;

  modport master (
    output ENABLE, INJ_REQ, EXT_REQ, DLY, WIDTH, GAP, NPULSE,
    input  INJ_PLS, EXT_PLS, BUSY, DONE, DROP_CNT
  );

  modport slave (
    input  ENABLE, INJ_REQ, EXT_REQ, DLY, WIDTH, GAP, NPULSE,
    output INJ_PLS, EXT_PLS, BUSY, DONE, DROP_CNT
  );
endinterface

// File: rtl/calib_pulse_seq.sv
// Calibration pulse sequencer: turns injection/external request edges into programmable pulse trains.
// Latency: request edge accepted at edge k, first pulse edge at k+1+DLY; all outputs registered.
// Backpressure: none; one pending slot per type, further edges are counted as drops (saturating).
module calib_pulse_seq #(
  parameter int DLY_W = 8,
  parameter int WID_W = 4,
  parameter int CNT_W = 8
) (
  input logic           CLK,
  input logic           RST,
  calib_pulse_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_GAP} state_t;

  state_t           state_q, state_nxt;
  logic             inj_d, ext_d;
  logic             inj_pend, ext_pend;
  logic             start_q;
  logic             sel_ext_q;
  logic [DLY_W-1:0] dly_lat;
  logic [WID_W-1:0] wid_lat, gap_lat;
  logic [CNT_W-1:0] npl_lat;
  logic [DLY_W-1:0] cnt_q, cnt_nxt;
  logic [CNT_W-1:0] pls_q, pls_nxt;
  logic             done_nxt;
  logic [DLY_W-1:0] wid_m1, gap_m1;

  logic             inj_edge, ext_edge;
  logic             can_start, inj_start, ext_start;
  logic             inj_drop, ext_drop;
  logic [CNT_W:0]   drop_sum;

  // Edge detect and arbitration: INJ (fresh or pending) wins over EXT; an edge that
  // cannot start goes to its slot, or is dropped if the slot is already occupied.
  always_comb begin
    inj_edge  = bus.INJ_REQ & ~inj_d;
    ext_edge  = bus.EXT_REQ & ~ext_d;
    can_start = bus.ENABLE & (state_q == S_IDLE) & ~start_q;
    inj_start = can_start & (inj_pend | inj_edge);
    ext_start = can_start & ~inj_start & (ext_pend | ext_edge);
    inj_drop  = bus.ENABLE & ~inj_start & inj_edge & inj_pend;
    ext_drop  = bus.ENABLE & ~ext_start & ext_edge & ext_pend;
    drop_sum  = {1'b0, bus.DROP_CNT} + (CNT_W+1)'(inj_drop) + (CNT_W+1)'(ext_drop);
  end

  // Request history, pending slots and the saturating drop counter.
  // A start consumes a pending slot; a fresh edge arriving in the same cycle refills it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      inj_d        <= 1'b0;
      ext_d        <= 1'b0;
      inj_pend     <= 1'b0;
      ext_pend     <= 1'b0;
      start_q      <= 1'b0;
      bus.DROP_CNT <= '0;
    end else begin
      inj_d   <= bus.INJ_REQ;
      ext_d   <= bus.EXT_REQ;
      start_q <= inj_start | ext_start;
      if (!bus.ENABLE) begin
        inj_pend <= 1'b0;
        ext_pend <= 1'b0;
      end else begin
        inj_pend <= inj_start ? (inj_pend & inj_edge) : (inj_pend | inj_edge);
        ext_pend <= ext_start ? (ext_pend & ext_edge) : (ext_pend | ext_edge);
      end
      if (drop_sum[CNT_W]) begin
        bus.DROP_CNT <= '1;
      end else begin
        bus.DROP_CNT <= drop_sum[CNT_W-1:0];
      end
    end
  end

  // Settings snapshot at acceptance so later input changes cannot disturb a running train.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_ext_q <= 1'b0;
      dly_lat   <= '0;
      wid_lat   <= WID_W'(1);
      gap_lat   <= WID_W'(1);
      npl_lat   <= CNT_W'(1);
    end else if (inj_start | ext_start) begin
      sel_ext_q <= ext_start;
      dly_lat   <= bus.DLY;
      wid_lat   <= (bus.WIDTH == '0) ? WID_W'(1) : bus.WIDTH;
      gap_lat   <= (bus.GAP == '0) ? WID_W'(1) : bus.GAP;
      npl_lat   <= (bus.NPULSE == '0) ? CNT_W'(1) : bus.NPULSE;
    end
  end

  // Next-state and counter logic; ENABLE low overrides everything back to IDLE without DONE.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pls_nxt   = pls_q;
    done_nxt  = 1'b0;
    wid_m1    = DLY_W'(wid_lat) - DLY_W'(1);
    gap_m1    = DLY_W'(gap_lat) - DLY_W'(1);
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          pls_nxt = npl_lat;
          if (dly_lat == '0) begin
            state_nxt = S_HIGH;
            cnt_nxt   = wid_m1;
          end else begin
            state_nxt = S_DELAY;
            cnt_nxt   = dly_lat - DLY_W'(1);
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_nxt = S_HIGH;
          cnt_nxt   = wid_m1;
        end else begin
          cnt_nxt = cnt_q - DLY_W'(1);
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          if (pls_q <= CNT_W'(1)) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            pls_nxt   = pls_q - CNT_W'(1);
            state_nxt = S_GAP;
            cnt_nxt   = gap_m1;
          end
        end else begin
          cnt_nxt = cnt_q - DLY_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_nxt = S_HIGH;
          cnt_nxt   = wid_m1;
        end else begin
          cnt_nxt = cnt_q - DLY_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!bus.ENABLE) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b0;
    end
  end

  // State register plus outputs registered from the next state, so outputs track state exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pls_q       <= '0;
      bus.INJ_PLS <= 1'b0;
      bus.EXT_PLS <= 1'b0;
      bus.BUSY    <= 1'b0;
      bus.DONE    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      pls_q       <= pls_nxt;
      bus.INJ_PLS <= (state_nxt == S_HIGH) & ~sel_ext_q;
      bus.EXT_PLS <= (state_nxt == S_HIGH) & sel_ext_q;
      bus.BUSY    <= (state_nxt != S_IDLE);
      bus.DONE    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_calib_pulse_seq.sv
// Bench for calib_pulse_seq: directed scenarios followed by random requests/settings.
// Expected trains come from a train-level model (arithmetic on latched settings).
// A monitor pops expected trains on DONE and compares timing, type and pulse counts.
module tb_calib_pulse_seq;
  localparam int DLY_W = 8;
  localparam int WID_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calib_pulse_seq_if #(.DLY_W(DLY_W), .WID_W(WID_W), .CNT_W(CNT_W)) bus ();

  calib_pulse_seq #(.DLY_W(DLY_W), .WID_W(WID_W), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    bit ext;
    int first;
    int npl;
    int hi;
    int done;
    int busy;
  } train_t;

  train_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  // train-level reference model state
  bit m_prev_inj = 0, m_prev_ext = 0, m_inj_p = 0, m_ext_p = 0, m_in_train = 0;
  bit quiet_flag = 0;
  int m_drop = 0;
  int m_busy_until = -1;
  int m_cur_done = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at edge %0d", name, act, exp, edge_no);
    end
  endtask

  task automatic bump_drop();
    if (m_drop < 255) m_drop++;
  endtask

  task automatic model_start(bit ext, int e);
    train_t t;
    int d, w, g, n;
    d = int'(bus.DLY);
    w = (bus.WIDTH == 0) ? 1 : int'(bus.WIDTH);
    g = (bus.GAP == 0) ? 1 : int'(bus.GAP);
    n = (bus.NPULSE == 0) ? 1 : int'(bus.NPULSE);
    t.ext   = ext;
    t.first = e + 1 + d;
    t.npl   = n;
    t.hi    = n * w;
    t.done  = e + 1 + d + n * w + (n - 1) * g;
    t.busy  = t.done - e - 1;
    exp_q.push_back(t);
    m_in_train   = 1;
    m_cur_done   = t.done;
    m_busy_until = t.done;
  endtask

  // Apply the rules to the inputs sampled at the edge that just happened.
  task automatic model_edge();
    int e;
    bit ie, ee;
    e  = edge_no;
    ie = bus.INJ_REQ && !m_prev_inj;
    ee = bus.EXT_REQ && !m_prev_ext;
    m_prev_inj = bus.INJ_REQ;
    m_prev_ext = bus.EXT_REQ;
    if (rst || !bus.ENABLE) begin
      if (m_in_train && e <= m_cur_done) begin
        void'(exp_q.pop_back());
        m_busy_until = e;
      end
      m_in_train = 0;
      m_inj_p    = 0;
      m_ext_p    = 0;
      quiet_flag = 1;
      if (rst) begin
        m_drop     = 0;
        m_prev_inj = 0;
        m_prev_ext = 0;
      end
    end else if (e > m_busy_until) begin
      if (m_inj_p || ie) begin
        model_start(0, e);
        m_inj_p = m_inj_p && ie;
        if (ee) begin
          if (m_ext_p) bump_drop(); else m_ext_p = 1;
        end
      end else if (m_ext_p || ee) begin
        model_start(1, e);
        m_ext_p = m_ext_p && ee;
      end
    end else begin
      if (ie) begin
        if (m_inj_p) bump_drop(); else m_inj_p = 1;
      end
      if (ee) begin
        if (m_ext_p) bump_drop(); else m_ext_p = 1;
      end
    end
  endtask

  task automatic step(bit r, bit en, bit inj, bit ext);
    @(posedge clk);
    #1;
    model_edge();
    rst         = r;
    bus.ENABLE  = en;
    bus.INJ_REQ = inj;
    bus.EXT_REQ = ext;
  endtask

  task automatic set_cfg(int d, int w, int g, int n);
    bus.DLY    = DLY_W'(d);
    bus.WIDTH  = WID_W'(w);
    bus.GAP    = WID_W'(g);
    bus.NPULSE = CNT_W'(n);
  endtask

  task automatic req_pulse(bit inj, bit ext);
    step(0, 1, inj, ext);
    step(0, 1, 0, 0);
  endtask

  task automatic drain(int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || edge_no <= m_busy_until + 1) && n < limit) begin
      step(0, 1, 0, 0);
      n++;
    end
    chk("drain_pending_trains", exp_q.size(), 0);
  endtask

  // monitor: observes the DUT every cycle, compares on DONE
  int ob_first = 0, ob_pulses = 0, ob_hi = 0, ob_busy = 0, ob_badtype = 0;
  bit ob_ext = 0, prev_pls = 0;

  task automatic clear_obs();
    ob_first = 0; ob_pulses = 0; ob_hi = 0; ob_busy = 0; ob_badtype = 0; ob_ext = 0;
  endtask

  initial begin
    train_t t;
    bit pi, pe, pl;
    forever begin
      @(negedge clk);
      pi = bus.INJ_PLS;
      pe = bus.EXT_PLS;
      pl = pi || pe;
      chk("pulse_exclusive", int'(pi && pe), 0);
      chk("drop_cnt", int'(bus.DROP_CNT), m_drop);
      if (quiet_flag) begin
        quiet_flag = 0;
        chk("quiet_outputs", int'({pi, pe, bus.BUSY, bus.DONE}), 0);
        clear_obs();
      end else begin
        if (pl) begin
          if (!prev_pls) begin
            if (ob_pulses == 0) begin
              ob_first = edge_no;
              ob_ext   = pe;
            end
            ob_pulses++;
          end
          ob_hi++;
          if (pe != ob_ext) ob_badtype++;
        end
        if (bus.BUSY) ob_busy++;
        if (bus.DONE) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            t = exp_q.pop_front();
            chk("train_type_ext", int'(ob_ext), int'(t.ext));
            chk("train_first_edge", ob_first, t.first);
            chk("train_pulses", ob_pulses, t.npl);
            chk("train_high_cycles", ob_hi, t.hi);
            chk("train_done_edge", edge_no, t.done);
            chk("train_busy_cycles", ob_busy, t.busy);
            chk("train_mixed_type", ob_badtype, 0);
          end
          clear_obs();
        end
      end
      prev_pls = pl;
    end
  end

  initial begin
    bit ri, re, ren, rr;
    bus.ENABLE  = 0;
    bus.INJ_REQ = 0;
    bus.EXT_REQ = 0;
    set_cfg(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);

    // single injection train, then multi-pulse external train with zero settings
    set_cfg(3, 2, 0, 1);
    repeat (4) step(0, 1, 0, 0);
    req_pulse(1, 0);
    drain(100);
    set_cfg(0, 0, 0, 3);
    req_pulse(0, 1);
    drain(100);

    // simultaneous edges: INJ first, EXT from its pending slot
    set_cfg(1, 1, 0, 1);
    req_pulse(1, 1);
    drain(100);

    // extra edges during a long train: one pending, two dropped; settings change after start
    set_cfg(10, 2, 1, 2);
    req_pulse(1, 0);
    repeat (3) req_pulse(1, 0);
    set_cfg(0, 1, 1, 1);
    drain(200);

    // enable dropped mid-HIGH with EXT pending, then a normal train after re-enable
    set_cfg(5, 8, 1, 3);
    req_pulse(1, 0);
    req_pulse(0, 1);
    repeat (4) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (30) step(0, 1, 0, 0);
    req_pulse(1, 0);
    drain(200);

    // build up five drops, then reset during a gap
    set_cfg(20, 3, 10, 5);
    req_pulse(1, 0);
    repeat (6) req_pulse(1, 0);
    repeat (15) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    drain(50);

    // drop counter saturation over 300 lost requests, then abort the long train
    set_cfg(255, 15, 15, 255);
    req_pulse(1, 0);
    repeat (301) req_pulse(1, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    drain(50);

    // random requests, settings, enable drops and rare resets
    ri = 0;
    re = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) ri = ~ri;
      if ($urandom_range(0, 4) == 0) re = ~re;
      ren = ($urandom_range(0, 299) != 0);
      rr  = ($urandom_range(0, 1999) == 0);
      set_cfg($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      step(rr, ren, ri, re);
    end
    drain(500);
    repeat (2) step(0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
